// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared types and reset constants for the uart transmit scheduler
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        TS_IDLE  = 2'd0,
        TS_XFER  = 2'd1,
        TS_DRAIN = 2'd2,
        TS_CFG   = 2'd3
    } ts_state_t;

    // 16-deep FIFO needs to represent 0..16 inclusive
    localparam int         UART_FIFO_COUNTER_W = 5;
    localparam logic [7:0] UART_LCR_RST        = 8'h83;
    localparam logic [7:0] UART_DL_RST         = 8'd27;

endpackage

// File: rtl/uart_rr_arb.sv
// rtl/uart_rr_arb.sv - combinational round-robin picker, first request at or after ptr
module uart_rr_arb
    import uart_tx_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] back;
    logic [N-1:0]   rot;
    logic [N-1:0]   pick;

    // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
    always_comb begin
        dbl  = {req, req} >> ptr;
        rot  = dbl[N-1:0];
        pick = rot & (~rot + N'(1));
        back = {pick, pick} << ptr;
        gnt  = back[2*N-1:N];
        any  = |req;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - packet round-robin scheduler and drain-safe line config for the uart transmit FIFO
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int         N          = 4,
    parameter int         FIFO_DEPTH = 16,
    parameter int         CNT_W      = UART_FIFO_COUNTER_W,
    parameter int         DRAIN_CYC  = 2048,
    parameter logic [7:0] LCR_RST    = UART_LCR_RST,
    parameter logic [7:0] DL_RST     = UART_DL_RST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ready,
    output logic [N-1:0]     grant,
    input  logic             cfg_valid,
    input  logic [7:0]       cfg_lcr,
    input  logic [7:0]       cfg_dl,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic [7:0]       lcr,
    output logic [7:0]       dl,
    output logic [7:0]       tdr,
    output logic             tf_push,
    input  logic [CNT_W-1:0] tf_count,
    output logic             busy
);

    localparam int             PW         = (N > 1) ? $clog2(N) : 1;
    localparam int             DW         = $clog2(DRAIN_CYC + 1);
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [CNT_W:0] DEPTH_L    = (CNT_W + 1)'(FIFO_DEPTH);

    ts_state_t     state, state_d;
    logic [N-1:0]  grant_d;
    logic [PW-1:0] rr_ptr, rr_ptr_d;
    logic [DW-1:0] drain_cnt, drain_cnt_d;
    logic          load_cfg;
    logic          cfg_pend;
    logic [7:0]    sh_lcr, sh_dl;

    logic [N-1:0]  arb_gnt;
    logic          arb_any;
    logic [7:0]    own_data;
    logic          own_last;
    logic [PW-1:0] own_idx;
    logic [CNT_W:0] fill;
    logic          space_ok;
    logic          hs;
    logic          fifo_idle;

    uart_rr_arb #(.N(N), .PW(PW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    always_comb begin
        own_data = '0;
        own_last = 1'b0;
        own_idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                own_data = req_data[8*i +: 8];
                own_last = req_last[i];
                own_idx  = PW'(i);
            end
        end
    end

    // tf_count lags our push by one cycle, so the in-flight push is added back
    assign fill      = {1'b0, tf_count} + {{CNT_W{1'b0}}, tf_push};
    assign space_ok  = fill < DEPTH_L;
    assign req_ready = (state == TS_XFER && space_ok) ? grant : '0;
    assign hs        = |(req_valid & req_ready);
    assign fifo_idle = (tf_count == '0) && !tf_push;
    assign cfg_ready = !cfg_pend;
    assign busy      = (state != TS_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TS_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        grant_d     = grant;
        rr_ptr_d    = rr_ptr;
        drain_cnt_d = drain_cnt;
        load_cfg    = 1'b0;
        case (state)
            TS_IDLE: begin
                if (cfg_pend) begin
                    drain_cnt_d = '0;
                    state_d     = TS_DRAIN;
                end else if (arb_any) begin
                    grant_d = arb_gnt;
                    state_d = TS_XFER;
                end
            end
            TS_XFER: begin
                if (hs && own_last) begin
                    rr_ptr_d = (own_idx == PW'(N - 1)) ? '0 : own_idx + PW'(1);
                    grant_d  = '0;
                    state_d  = TS_IDLE;
                end
            end
            TS_DRAIN: begin
                // the hold-off only counts once the FIFO is empty and nothing is in flight
                if (fifo_idle) begin
                    if (drain_cnt == DRAIN_LAST) begin
                        drain_cnt_d = '0;
                        state_d     = TS_CFG;
                    end else begin
                        drain_cnt_d = drain_cnt + DW'(1);
                    end
                end else begin
                    drain_cnt_d = '0;
                end
            end
            TS_CFG: begin
                load_cfg = 1'b1;
                state_d  = TS_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = TS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant     <= '0;
            rr_ptr    <= '0;
            drain_cnt <= '0;
            tf_push   <= 1'b0;
            tdr       <= '0;
            cfg_done  <= 1'b0;
        end else begin
            grant     <= grant_d;
            rr_ptr    <= rr_ptr_d;
            drain_cnt <= drain_cnt_d;
            tf_push   <= hs;
            cfg_done  <= load_cfg;
            if (hs) begin
                tdr <= own_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_pend <= 1'b0;
            sh_lcr   <= LCR_RST;
            sh_dl    <= DL_RST;
            lcr      <= LCR_RST;
            dl       <= DL_RST;
        end else if (load_cfg) begin
            lcr      <= sh_lcr;
            dl       <= sh_dl;
            cfg_pend <= 1'b0;
        end else if (cfg_valid && !cfg_pend) begin
            sh_lcr   <= cfg_lcr;
            sh_dl    <= cfg_dl;
            cfg_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched with a simple uart FIFO count model
module tb_uart_tx_sched;

    localparam int N          = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = 5;
    localparam int DRAIN_CYC  = 40;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     grant;
    logic             cfg_valid = 1'b0;
    logic [7:0]       cfg_lcr = '0;
    logic [7:0]       cfg_dl = '0;
    logic             cfg_ready;
    logic             cfg_done;
    logic [7:0]       lcr, dl, tdr;
    logic             tf_push;
    logic [CNT_W-1:0] tf_count = '0;
    logic             busy;

    uart_tx_sched #(
        .N(N), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC),
        .LCR_RST(8'h83), .DL_RST(8'd27)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .cfg_valid(cfg_valid), .cfg_lcr(cfg_lcr), .cfg_dl(cfg_dl),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done),
        .lcr(lcr), .dl(dl), .tdr(tdr), .tf_push(tf_push),
        .tf_count(tf_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0]   src_q [N][$];
    logic [7:0]   exp_q [$];
    logic [N-1:0] gexp_q [$];
    logic [15:0]  cexp_q [$];

    int           push_cnt = 0;
    int           done_cnt = 0;
    int           zero_run = 0;
    int           last_done_run = 0;
    logic [N-1:0] prev_grant = '0;
    logic [7:0]   prev_lcr = 8'h83;
    logic [7:0]   prev_dl = 8'd27;

    logic             cnt_load = 1'b0;
    logic [CNT_W-1:0] cnt_val = '0;
    logic             pop_en = 1'b1;
    int               pop_div = 0;

    int order [5] = '{0, 1, 2, 3, 0};
    int pcnt  [N];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit src_empty();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // uart FIFO occupancy: sees our push at the next edge, drains one byte every third cycle
    always @(posedge clk) begin
        if (rst) begin
            tf_count <= '0;
            pop_div  <= 0;
        end else if (cnt_load) begin
            tf_count <= cnt_val;
        end else begin
            pop_div  <= (pop_div == 2) ? 0 : pop_div + 1;
            tf_count <= CNT_W'(int'(tf_count) + int'(tf_push)
                        - ((pop_en && pop_div == 0 && tf_count != '0) ? 1 : 0));
        end
    end

    initial begin
        logic [N-1:0] hs;
        logic [8:0]   e;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    e = src_q[i][0];
                    req_valid[i]      = 1'b1;
                    req_data[8*i +: 8] = e[7:0];
                    req_last[i]       = e[8];
                end else begin
                    req_valid[i]      = 1'b0;
                    req_data[8*i +: 8] = '0;
                    req_last[i]       = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tf_push) begin
                    push_cnt++;
                    check("fifo_bound", int'(tf_count) + 1 <= FIFO_DEPTH, 1);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_push: tdr %0h with empty scoreboard", tdr);
                    end else begin
                        check("tdr", tdr, exp_q.pop_front());
                    end
                end
                if (grant != '0 && grant != prev_grant) begin
                    if (gexp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_grant: grant %0b", grant);
                    end else begin
                        check("grant", grant, gexp_q.pop_front());
                    end
                end
                if (req_ready != '0) check("ready_owner", req_ready & ~grant, 0);
                zero_run = (tf_count == '0 && !tf_push) ? zero_run + 1 : 0;
                if (cfg_done) begin
                    done_cnt++;
                    last_done_run = zero_run;
                    check("drain_len", zero_run >= DRAIN_CYC + 2, 1);
                    if (cexp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_cfg_done: lcr %0h dl %0h", lcr, dl);
                    end else begin
                        check("cfg_apply", {lcr, dl}, cexp_q.pop_front());
                    end
                end else if (lcr != prev_lcr || dl != prev_dl) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL early_cfg_apply: lcr %0h dl %0h without cfg_done", lcr, dl);
                end
            end
            prev_grant = grant;
            prev_lcr   = lcr;
            prev_dl    = dl;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(string name, int budget);
        int k = 0;
        while ((exp_q.size() != 0 || !src_empty() || busy) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, k < budget, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        gexp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        int k;
        int p0;
        int bad;
        logic [7:0] b;

        #1;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_lcr", lcr, 8'h83);
        check("rst_dl", dl, 8'd27);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_grant", grant, 0);
        check("rst_tf_push", tf_push, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_done", cfg_done, 0);
        @(posedge clk);
        #1;

        // reset while requester 1 is mid-packet
        for (int j = 0; j < 10; j++) begin
            src_q[1].push_back({j == 9, 8'(8'h10 + j)});
            exp_q.push_back(8'(8'h10 + j));
        end
        gexp_q.push_back(4'b0010);
        k = 0;
        do begin @(negedge clk); k++; end while (!tf_push && k < 50);
        check("t1_first_push", tf_push, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t1_rst_tf_push", tf_push, 0);
        check("t1_rst_grant", grant, 0);
        check("t1_rst_ready", req_ready, 0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        gexp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(4);
        check("t1_no_push_after_rst", push_cnt, push_cnt);

        // two-byte packet from requester 2
        src_q[2].push_back({1'b0, 8'hA5});
        src_q[2].push_back({1'b1, 8'h5A});
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        gexp_q.push_back(4'b0100);
        k = 0;
        do begin @(negedge clk); k++; end while (!tf_push && k < 50);
        check("t2_push1", tf_push, 1);
        check("t2_tdr1", tdr, 8'hA5);
        check("t2_grant", grant, 4'b0100);
        @(negedge clk);
        check("t2_push2", tf_push, 1);
        check("t2_tdr2", tdr, 8'h5A);
        check("t2_grant_released", grant, 0);
        check("t2_rr_ptr", dut.rr_ptr, 3);
        @(posedge clk);
        #1;
        wait_idle("t2_done", 200);

        // all requesters valid from rr_ptr 0
        do_reset();
        for (int i = 0; i < N; i++) pcnt[i] = 0;
        for (int j = 0; j < 5; j++) begin
            for (int bi = 0; bi < 3; bi++) begin
                b = 8'(order[j] * 16 + pcnt[order[j]] * 4 + bi);
                src_q[order[j]].push_back({bi == 2, b});
                exp_q.push_back(b);
            end
            gexp_q.push_back(N'(1 << order[j]));
            pcnt[order[j]]++;
        end
        wait_idle("t3_done", 1000);
        check("t3_rr_ptr", dut.rr_ptr, 1);
        check("t3_grants_seen", gexp_q.size(), 0);

        // back-pressure around a full FIFO
        pop_en   = 1'b0;
        cnt_val  = 5'd15;
        cnt_load = 1'b1;
        tick(1);
        cnt_load = 1'b0;
        p0 = push_cnt;
        for (int j = 0; j < 6; j++) begin
            src_q[3].push_back({j == 5, 8'(8'hC0 + j)});
            exp_q.push_back(8'(8'hC0 + j));
        end
        gexp_q.push_back(4'b1000);
        tick(12);
        check("t4_one_push", push_cnt - p0, 1);
        check("t4_count_full", tf_count, 16);
        check("t4_ready_low", req_ready, 0);
        cnt_val  = 5'd14;
        cnt_load = 1'b1;
        tick(1);
        cnt_load = 1'b0;
        tick(12);
        check("t4_resume_pushes", push_cnt - p0, 3);
        check("t4_count_full2", tf_count, 16);
        pop_en = 1'b1;
        wait_idle("t4_done", 1000);

        // config request during a 20-byte packet
        for (int j = 0; j < 20; j++) begin
            src_q[1].push_back({j == 19, 8'(8'h40 + j)});
            exp_q.push_back(8'(8'h40 + j));
        end
        gexp_q.push_back(4'b0010);
        k = 0;
        while (grant != 4'b0010 && k < 50) begin tick(1); k++; end
        check("t5_granted", grant, 4'b0010);
        cfg_valid = 1'b1;
        cfg_lcr   = 8'h87;
        cfg_dl    = 8'd54;
        cexp_q.push_back({8'h87, 8'd54});
        p0 = done_cnt;
        tick(1);
        cfg_valid = 1'b0;
        check("t5_cfg_ready_low", cfg_ready, 0);
        k = 0;
        do begin @(negedge clk); k++; end while (!cfg_done && k < 1000);
        check("t5_cfg_done", cfg_done, 1);
        check("t5_packet_complete", exp_q.size(), 0);
        check("t5_drain_exact", last_done_run, DRAIN_CYC + 2);
        check("t5_lcr", lcr, 8'h87);
        check("t5_dl", dl, 8'd54);
        check("t5_cfg_ready", cfg_ready, 1);
        @(negedge clk);
        check("t5_done_pulse", cfg_done, 0);
        check("t5_done_once", done_cnt - p0, 1);
        @(posedge clk);
        #1;

        // pending config beats a waiting requester
        cfg_valid = 1'b1;
        cfg_lcr   = 8'h03;
        cfg_dl    = 8'd13;
        cexp_q.push_back({8'h03, 8'd13});
        tick(1);
        cfg_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            src_q[0].push_back({j == 3, 8'(8'hE0 + j)});
            exp_q.push_back(8'(8'hE0 + j));
        end
        gexp_q.push_back(4'b0001);
        bad = 0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (grant != '0 && !cfg_done) bad = 1;
        end while (!cfg_done && k < 1000);
        check("t6_cfg_done", cfg_done, 1);
        check("t6_no_grant_before_cfg", bad, 0);
        check("t6_lcr", lcr, 8'h03);
        @(posedge clk);
        #1;
        wait_idle("t6_done", 500);
        check("t6_rr_ptr", dut.rr_ptr, 1);
        check("t6_grants_seen", gexp_q.size(), 0);
        check("t6_cfgs_seen", cexp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
